// File: rtl/bht_update_scheduler.sv
// rtl/bht_update_scheduler.sv - BHT update queue: issues one resolved branch per cycle to the BHT write port
// Defers a head whose index matches the fetch read, forcing it through after DEFER_MAX deferrals.
module bht_update_scheduler #(
  parameter int INDEX_LEN  = 7,
  parameter int TAG_LEN    = 7,
  parameter int DEPTH_LOG2 = 2,
  parameter int DEFER_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [INDEX_LEN-1:0]  upd_index,
  input  logic [TAG_LEN-1:0]    upd_tag,
  input  logic                  upd_taken,
  input  logic [INDEX_LEN-1:0]  rd_index,
  input  logic                  rd_active,
  input  logic                  pause,
  output logic [INDEX_LEN-1:0]  bht_index_write,
  output logic [TAG_LEN-1:0]    bht_tag_write,
  output logic                  bht_inc_dec,
  output logic                  bht_write_enabled,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  forced_issue
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (DEFER_MAX < 1) ? 1 : $clog2(DEFER_MAX + 1);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  logic [INDEX_LEN-1:0]  mem_index [DEPTH];
  logic [TAG_LEN-1:0]    mem_tag   [DEPTH];
  logic                  mem_taken [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   occ_next;
  logic [CW-1:0]         defer_cnt;
  state_t                state, state_next;
  logic                  push, head_valid, conflict;
  logic                  do_issue, do_force, defer_inc;

  assign push       = upd_valid && upd_ready;
  assign head_valid = (occupancy != '0);
  assign conflict   = rd_active && (rd_index == mem_index[rd_ptr]);

  // Entry payload needs no reset; validity is tracked by occupancy alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_index[wr_ptr] <= upd_index;
      mem_tag[wr_ptr]   <= upd_tag;
      mem_taken[wr_ptr] <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!pause) begin
      if (occ_next == '0) begin
        state_next = IDLE;
      end else if (defer_inc) begin
        state_next = HOLD;
      end else begin
        state_next = ISSUE;
      end
    end
  end

  // Issue rules apply in every state so a head arriving in IDLE issues one edge after its push.
  always_comb begin
    do_issue  = 1'b0;
    do_force  = 1'b0;
    defer_inc = 1'b0;
    if (head_valid && !pause) begin
      if (!conflict) begin
        do_issue = 1'b1;
      end else if (defer_cnt == CW'(DEFER_MAX)) begin
        do_issue = 1'b1;
        do_force = 1'b1;
      end else begin
        defer_inc = 1'b1;
      end
    end
  end

  always_comb begin
    occ_next = occupancy;
    if (push && !do_issue) begin
      occ_next = occupancy + 1'b1;
    end else if (!push && do_issue) begin
      occ_next = occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occupancy         <= '0;
      upd_ready         <= 1'b0;
      defer_cnt         <= '0;
      bht_write_enabled <= 1'b0;
      forced_issue      <= 1'b0;
      bht_index_write   <= '0;
      bht_tag_write     <= '0;
      bht_inc_dec       <= 1'b0;
    end else begin
      occupancy         <= occ_next;
      upd_ready         <= (occ_next != FULL);
      bht_write_enabled <= do_issue;
      forced_issue      <= do_force;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_issue) begin
        rd_ptr          <= rd_ptr + 1'b1;
        defer_cnt       <= '0;
        bht_index_write <= mem_index[rd_ptr];
        bht_tag_write   <= mem_tag[rd_ptr];
        bht_inc_dec     <= mem_taken[rd_ptr];
      end else if (defer_inc) begin
        defer_cnt <= defer_cnt + 1'b1;
      end
    end
  end

endmodule
